cart_mapper: RTL and testbench

- Cartridge bank-switching mapper, directly upstream of the 32K cartridge ROM (dprom) in atari_2600.
- Snoops the CPU address bus and detects hotspot accesses.
- Holds bank and slice state, and produces the ROM read address.
- Infers cartridge size from the ESP32 SPI ROM-load stream and selects the mapping scheme: NONE, F8, FE, F6, F4 or E0.

---
 rtl/cart_mapper_pkg.sv | 30 +++
 rtl/cart_mapper_if.sv | 39 +++
 rtl/cart_mapper_size_detect.sv | 48 ++++
 rtl/cart_mapper.sv | 160 ++++++++++++++++
 tb/tb_cart_mapper.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cart_mapper_pkg.sv
// cart_mapper_pkg: shared types and constants for the cartridge bank-switching
// mapper.
//   scheme_t        - mapping scheme codes as reported on the scheme output
//   HS_*            - hotspot addresses on the 13-bit 6507 address bus
//   E0_FIXED_SLICE  - bank permanently mapped into the top 1K slice in E0 mode
package cart_mapper_pkg;

  typedef enum logic [2:0] {
    SCHEME_NONE = 3'd0,
    SCHEME_F8   = 3'd1,
    SCHEME_FE   = 3'd2,
    SCHEME_F6   = 3'd3,
    SCHEME_F4   = 3'd4,
    SCHEME_E0   = 3'd5
  } scheme_t;

  localparam logic [12:0] HS_F8_BANK0 = 13'h1FF8;
  localparam logic [12:0] HS_F8_BANK1 = 13'h1FF9;
  localparam logic [12:0] HS_FE_BANK0 = 13'h01FE;
  localparam logic [12:0] HS_FE_BANK1 = 13'h11FE;
  localparam logic [12:0] HS_F6_FIRST = 13'h1FF6;
  localparam logic [12:0] HS_F6_LAST  = 13'h1FF9;
  localparam logic [12:0] HS_F4_FIRST = 13'h1FF4;
  localparam logic [12:0] HS_F4_LAST  = 13'h1FFB;
  localparam logic [12:0] HS_E0_FIRST = 13'h1FE0;
  localparam logic [12:0] HS_E0_LAST  = 13'h1FF7;

  localparam logic [2:0] E0_FIXED_SLICE = 3'd7;

endpackage

// File: rtl/cart_mapper_if.sv
// cart_mapper_if: CPU bus snoop, SPI ROM-load stream and ROM/cart-RAM result
// signals between the console core (master) and cart_mapper (slave).
//   bus_strobe    - one clk_sys pulse per CPU cycle, address stable
//   cpu_addr      - CPU address bus
//   cpu_rnw       - CPU read/not-write
//   cpu_dout      - CPU write data
//   load_active   - SPI ROM load in progress (CPU stalled)
//   load_wr       - one-cycle ROM byte write strobe from the SPI slave
//   load_addr     - ROM byte address of load_wr
//   rom_addr      - mapped ROM read address
//   cart_ram_cs   - CPU is addressing cart RAM
//   cart_ram_dout - cart RAM read data
interface cart_mapper_if #(
  parameter int ROM_AW = 15,
  parameter int CPU_AW = 13
);
  logic              bus_strobe;
  logic [CPU_AW-1:0] cpu_addr;
  logic              cpu_rnw;
  logic [7:0]        cpu_dout;
  logic              load_active;
  logic              load_wr;
  logic [ROM_AW-1:0] load_addr;
  logic [ROM_AW-1:0] rom_addr;
  logic              cart_ram_cs;
  logic [7:0]        cart_ram_dout;

  modport master (
    output bus_strobe, cpu_addr, cpu_rnw, cpu_dout,
    output load_active, load_wr, load_addr,
    input  rom_addr, cart_ram_cs, cart_ram_dout
  );

  modport slave (
    input  bus_strobe, cpu_addr, cpu_rnw, cpu_dout,
    input  load_active, load_wr, load_addr,
    output rom_addr, cart_ram_cs, cart_ram_dout
  );
endinterface

// File: rtl/cart_mapper_size_detect.sv
// cart_size_detect: infers the cartridge image size from the SPI ROM-load
// stream and decodes the active mapping scheme.
//   clk_sys   - system clock
//   load_wr   - ROM byte write strobe
//   load_addr - ROM byte address of load_wr
//   fe_mode   - 8K image uses FE instead of F8
//   e0_mode   - 8K image uses E0 (takes priority over fe_mode)
//   scheme    - decoded scheme
// The size register has no reset: a CPU reset must not forget the loaded
// cartridge. It powers up as 0 through the FPGA configuration.
module cart_size_detect
  import cart_mapper_pkg::*;
(
  input  logic        clk_sys,
  input  logic        load_wr,
  input  logic [14:0] load_addr,
  input  logic        fe_mode,
  input  logic        e0_mode,
  output scheme_t     scheme
);

  // bit0: 8K+, bit1: 16K+, bit2: 32K
  logic [2:0] size;

  // A write at the start of any 16K half restarts detection; the address
  // bits of that same write are still recorded, so set follows clear.
  always_ff @(posedge clk_sys) begin
    if (load_wr) begin
      if (load_addr[13:0] == 14'd0) size <= load_addr[14:12];
      else                          size <= size | load_addr[14:12];
    end
  end

  always_comb begin
    scheme = SCHEME_NONE;
    case (size)
      3'b001: begin
        if (e0_mode)      scheme = SCHEME_E0;
        else if (fe_mode) scheme = SCHEME_FE;
        else              scheme = SCHEME_F8;
      end
      3'b011:  scheme = SCHEME_F6;
      3'b111:  scheme = SCHEME_F4;
      default: scheme = SCHEME_NONE;
    endcase
  end

endmodule

// File: rtl/cart_mapper.sv
// cart_mapper: cartridge bank-switching mapper in front of the 32K cart ROM.
// Snoops CPU hotspot accesses, holds bank / E0 slice state and forms the ROM
// read address for NONE, F8, FE, F6, F4 and E0 cartridges.
//   clk_sys   - system clock
//   reset     - synchronous, active-high; clears bank/slice state only
//   bus       - cart_mapper_if.slave (CPU snoop, load stream, ROM/RAM result)
//   fe_mode   - 8K image uses FE
//   e0_mode   - 8K image uses E0
//   sc_enable - Superchip RAM present
//   scheme    - active scheme code
//   bank      - current bank (slice 0 bank in E0 mode)
// Build option CART_MAPPER_SC_RAM_EN adds the 128x8 Superchip RAM
// (write 1000-107F, read 1080-10FF) for F8/F6/F4; without it cart_ram_cs and
// cart_ram_dout are tied to zero.
module cart_mapper
  import cart_mapper_pkg::*;
#(
  parameter int ROM_AW = 15,
  parameter int CPU_AW = 13
) (
  input  logic        clk_sys,
  input  logic        reset,
  cart_mapper_if.slave bus,
  input  logic        fe_mode,
  input  logic        e0_mode,
  input  logic        sc_enable,
  output logic [2:0]  scheme,
  output logic [2:0]  bank
);

  scheme_t           scheme_w;
  logic [CPU_AW-1:0] a;
  logic [CPU_AW-1:0] f6_off;
  logic [CPU_AW-1:0] f4_off;
  logic              hs_take;
  logic [2:0]        bank_reg, bank_next;
  logic [2:0]        slice0_reg, slice1_reg, slice2_reg;
  logic [2:0]        slice0_next, slice1_next, slice2_next;
  logic [2:0]        e0_sel;
  logic [ROM_AW-1:0] rom_addr_w;
  logic              unused_bits;

  cart_size_detect u_size (
    .clk_sys   (clk_sys),
    .load_wr   (bus.load_wr),
    .load_addr (bus.load_addr),
    .fe_mode   (fe_mode),
    .e0_mode   (e0_mode),
    .scheme    (scheme_w)
  );

  assign a       = bus.cpu_addr;
  assign f6_off  = a - CPU_AW'(HS_F6_FIRST);
  assign f4_off  = a - CPU_AW'(HS_F4_FIRST);
  assign hs_take = bus.bus_strobe && !bus.load_active;

  // Hotspot decode: next bank/slice as if this access were a strobed one.
  always_comb begin
    bank_next   = bank_reg;
    slice0_next = slice0_reg;
    slice1_next = slice1_reg;
    slice2_next = slice2_reg;
    case (scheme_w)
      SCHEME_F8: begin
        if (a == CPU_AW'(HS_F8_BANK0))      bank_next = 3'd0;
        else if (a == CPU_AW'(HS_F8_BANK1)) bank_next = 3'd1;
      end
      SCHEME_FE: begin
        if (a == CPU_AW'(HS_FE_BANK0))      bank_next = 3'd0;
        else if (a == CPU_AW'(HS_FE_BANK1)) bank_next = 3'd1;
      end
      SCHEME_F6: begin
        if (a >= CPU_AW'(HS_F6_FIRST) && a <= CPU_AW'(HS_F6_LAST))
          bank_next = f6_off[2:0];
      end
      SCHEME_F4: begin
        if (a >= CPU_AW'(HS_F4_FIRST) && a <= CPU_AW'(HS_F4_LAST))
          bank_next = f4_off[2:0];
      end
      SCHEME_E0: begin
        // 1FE0/1FE8/1FF0 groups differ only in addr[4:3]
        if (a >= CPU_AW'(HS_E0_FIRST) && a <= CPU_AW'(HS_E0_LAST)) begin
          case (a[4:3])
            2'b00:   slice0_next = a[2:0];
            2'b01:   slice1_next = a[2:0];
            default: slice2_next = a[2:0];
          endcase
        end
      end
      default: ;
    endcase
  end

  // Bank/slice state: updated on the strobe cycle, seen from the next cycle
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bank_reg   <= 3'd0;
      slice0_reg <= 3'd0;
      slice1_reg <= 3'd1;
      slice2_reg <= 3'd2;
    end else if (hs_take) begin
      bank_reg   <= bank_next;
      slice0_reg <= slice0_next;
      slice1_reg <= slice1_next;
      slice2_reg <= slice2_next;
    end
  end

  always_comb begin
    case (a[11:10])
      2'd0:    e0_sel = slice0_reg;
      2'd1:    e0_sel = slice1_reg;
      2'd2:    e0_sel = slice2_reg;
      default: e0_sel = E0_FIXED_SLICE;
    endcase
  end

  always_comb begin
    rom_addr_w = ROM_AW'({3'b000, a[11:0]});
    case (scheme_w)
      SCHEME_F8, SCHEME_FE, SCHEME_F6, SCHEME_F4:
        rom_addr_w = ROM_AW'({bank_reg, a[11:0]});
      SCHEME_E0:
        rom_addr_w = ROM_AW'({2'b00, e0_sel, a[9:0]});
      default:
        rom_addr_w = ROM_AW'({3'b000, a[11:0]});
    endcase
  end

  assign bus.rom_addr = rom_addr_w;
  assign scheme       = scheme_w;
  assign bank         = (scheme_w == SCHEME_E0) ? slice0_reg : bank_reg;

`ifdef CART_MAPPER_SC_RAM_EN
  logic [7:0] sc_mem [128];
  logic [7:0] ram_dout_p1;
  logic       ram_sel;

  // 1000-10FF, only for the schemes that carry a Superchip
  assign ram_sel = sc_enable && (a[12:8] == 5'h10) &&
                   (scheme_w == SCHEME_F8 || scheme_w == SCHEME_F6 ||
                    scheme_w == SCHEME_F4);

  // Stage p0 -> p1: write on strobe, registered read of the addressed byte
  always_ff @(posedge clk_sys) begin
    if (ram_sel && !a[7] && hs_take) sc_mem[a[6:0]] <= bus.cpu_dout;
    ram_dout_p1 <= sc_mem[a[6:0]];
  end

  assign bus.cart_ram_cs   = ram_sel;
  assign bus.cart_ram_dout = ram_dout_p1;
  // Superchip writes are decoded by address alone
  assign unused_bits = bus.cpu_rnw;
`else
  assign bus.cart_ram_cs   = 1'b0;
  assign bus.cart_ram_dout = 8'h00;
  assign unused_bits = ^{bus.cpu_rnw, bus.cpu_dout, sc_enable};
`endif

endmodule

// File: tb/tb_cart_mapper.sv
`timescale 1ns/1ps
module tb_cart_mapper;

  localparam int S_NONE = 0, S_F8 = 1, S_FE = 2, S_F6 = 3, S_F4 = 4, S_E0 = 5;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       fe_mode, e0_mode, sc_enable;
  logic [2:0] scheme, bank;

  always #5 clk_sys = ~clk_sys;

  cart_mapper_if bus ();

  cart_mapper dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .bus       (bus),
    .fe_mode   (fe_mode),
    .e0_mode   (e0_mode),
    .sc_enable (sc_enable),
    .scheme    (scheme),
    .bank      (bank)
  );

  typedef struct {
    int    rom_addr;
    int    bank;
    int    scheme;
    int    cs;
    int    dout;
    bit    chk_dout;
    string tag;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   chk_req = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Reference model: image length, bank, E0 slices, Superchip RAM contents
  int   m_len = 0;
  int   m_bank = 0;
  int   m_slice[3];
  int   m_mem[128];
  bit   m_written[128];

  function automatic int m_scheme();
    if (m_len == 8192)  return e0_mode ? S_E0 : (fe_mode ? S_FE : S_F8);
    if (m_len == 16384) return S_F6;
    if (m_len == 32768) return S_F4;
    return S_NONE;
  endfunction

  function automatic bit sc_on(int a);
`ifdef CART_MAPPER_SC_RAM_EN
    int s = m_scheme();
    return sc_enable && (s == S_F8 || s == S_F6 || s == S_F4) &&
           a >= 'h1000 && a <= 'h10FF;
`else
    return 1'b0;
`endif
  endfunction

  function automatic exp_t exp_for(int a, bit want_dout, string tag);
    exp_t e;
    int s = m_scheme();
    int lo = a % 4096;
    e.scheme = s;
    e.bank = (s == S_E0) ? m_slice[0] : m_bank;
    case (s)
      S_F8, S_FE, S_F6, S_F4: e.rom_addr = m_bank * 4096 + lo;
      S_E0: e.rom_addr = ((lo / 1024 == 3) ? 7 : m_slice[lo / 1024]) * 1024 + a % 1024;
      default: e.rom_addr = lo;
    endcase
    e.cs = sc_on(a);
    e.dout = 0;
    e.chk_dout = 1'b0;
    e.tag = tag;
`ifdef CART_MAPPER_SC_RAM_EN
    if (want_dout && e.cs != 0 && a >= 'h1080 && m_written[a - 'h1080]) begin
      e.dout = m_mem[a - 'h1080];
      e.chk_dout = 1'b1;
    end
`else
    e.chk_dout = want_dout;
`endif
    return e;
  endfunction

  task automatic cmp(string name, int act, int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, want);
    end
  endtask

  // Monitor: compares DUT outputs against queued expectations mid-cycle
  always @(negedge clk_sys) begin
    if (chk_req) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty got 0 expected 1");
      end else begin
        cur = q.pop_front();
        cmp({cur.tag, "_rom_addr"}, int'(bus.rom_addr), cur.rom_addr);
        cmp({cur.tag, "_bank"}, int'(bank), cur.bank);
        cmp({cur.tag, "_scheme"}, int'(scheme), cur.scheme);
        cmp({cur.tag, "_ram_cs"}, int'(bus.cart_ram_cs), cur.cs);
        if (cur.chk_dout) cmp({cur.tag, "_ram_dout"}, int'(bus.cart_ram_dout), cur.dout);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic model_reset();
    m_bank = 0;
    m_slice[0] = 0; m_slice[1] = 1; m_slice[2] = 2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic load_image(int len);
    bus.load_active = 1'b1;
    for (int i = 0; i < len; i++) begin
      bus.load_wr = 1'b1;
      bus.load_addr = 15'(i);
      tick();
      if (i == 0) m_len = 1;
      else if (i + 1 > m_len) m_len = i + 1;
    end
    bus.load_wr = 1'b0;
    bus.load_active = 1'b0;
    tick();
  endtask

  // Strobed access; the hotspot cycle itself must still show the old bank
  task automatic strobe(int a, bit la, int d, string tag);
    int s;
    bus.cpu_addr = 13'(a);
    bus.cpu_rnw = 1'($urandom);
    bus.cpu_dout = 8'(d);
    bus.load_active = la;
    bus.bus_strobe = 1'b1;
    q.push_back(exp_for(a, 1'b0, tag));
    chk_req = 1'b1;
    tick();
    chk_req = 1'b0;
    bus.bus_strobe = 1'b0;
    bus.load_active = 1'b0;
    if (!la) begin
      s = m_scheme();
      case (s)
        S_F8: begin
          if (a == 'h1FF8) m_bank = 0;
          else if (a == 'h1FF9) m_bank = 1;
        end
        S_FE: begin
          if (a == 'h01FE) m_bank = 0;
          else if (a == 'h11FE) m_bank = 1;
        end
        S_F6: if (a >= 'h1FF6 && a <= 'h1FF9) m_bank = a - 'h1FF6;
        S_F4: if (a >= 'h1FF4 && a <= 'h1FFB) m_bank = a - 'h1FF4;
        S_E0: if (a >= 'h1FE0 && a <= 'h1FF7) m_slice[(a - 'h1FE0) / 8] = a % 8;
        default: ;
      endcase
      if (sc_on(a) && a < 'h1080) begin
        m_mem[a - 'h1000] = d;
        m_written[a - 'h1000] = 1'b1;
      end
    end
  endtask

  // Unstrobed address held two cycles: comb outputs, then registered RAM data
  task automatic observe(int a, string tag);
    bus.cpu_addr = 13'(a);
    q.push_back(exp_for(a, 1'b0, tag));
    chk_req = 1'b1;
    tick();
    q.push_back(exp_for(a, 1'b1, tag));
    tick();
    chk_req = 1'b0;
  endtask

  function automatic int pick_addr();
    case ($urandom_range(0, 4))
      0, 1:    return 'h1FE0 + $urandom_range(0, 31);
      2:       return ($urandom_range(0, 1) != 0) ? 'h11FE : 'h01FE;
      3:       return 'h1000 + $urandom_range(0, 255);
      default: return $urandom_range(0, 8191);
    endcase
  endfunction

  task automatic rand_ops(int n, bit toggle_modes);
    for (int i = 0; i < n; i++) begin
      if (toggle_modes && $urandom_range(0, 15) == 0) begin
        fe_mode = 1'($urandom);
        e0_mode = 1'($urandom);
      end
      if ($urandom_range(0, 19) == 0) sc_enable = 1'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: strobe(pick_addr(), ($urandom_range(0, 9) == 0),
                              $urandom_range(0, 255), "rnd_strobe");
        5, 6, 7: observe(pick_addr(), "rnd_obs");
        8: observe($urandom_range(0, 8191), "rnd_any");
        default: if ($urandom_range(0, 3) == 0) do_reset();
      endcase
    end
  endtask

  initial begin
    reset = 1'b1;
    fe_mode = 1'b0; e0_mode = 1'b0; sc_enable = 1'b1;
    bus.bus_strobe = 1'b0; bus.cpu_addr = '0; bus.cpu_rnw = 1'b1; bus.cpu_dout = '0;
    bus.load_active = 1'b0; bus.load_wr = 1'b0; bus.load_addr = '0;
    for (int i = 0; i < 128; i++) begin m_mem[i] = 0; m_written[i] = 1'b0; end
    model_reset();
    tick(); tick();
    reset = 1'b0;
    observe('h1234, "reset_state");

    // 8K image: F8
    load_image(8192);
    observe('h1234, "f8_initial");
    strobe('h1FF9, 1'b0, 0, "f8_hs1");
    observe('h1234, "f8_bank1");
    strobe('h1FF8, 1'b0, 0, "f8_hs0");
    observe('h1234, "f8_bank0");
    observe('h1FF9, "f8_no_strobe");
    observe('h1234, "f8_still0");
    strobe('h1005, 1'b0, 'hA5, "sc_write");
    observe('h1085, "sc_read");
    sc_enable = 1'b0;
    observe('h1085, "sc_disabled");
    sc_enable = 1'b1;
    reset = 1'b1;
    strobe('h1FF9, 1'b0, 0, "reset_vs_hs");
    reset = 1'b0;
    model_reset();
    observe('h1234, "reset_wins");
    fe_mode = 1'b1;
    strobe('h11FE, 1'b0, 0, "fe_hs1");
    observe('h1234, "fe_bank1");
    fe_mode = 1'b0;
    rand_ops(150, 1'b1);

    // 8K image as E0
    e0_mode = 1'b1;
    do_reset();
    strobe('h1FE5, 1'b0, 0, "e0_s0");
    strobe('h1FEB, 1'b0, 0, "e0_s1");
    strobe('h1FF2, 1'b0, 0, "e0_s2");
    observe('h1000, "e0_slice0");
    observe('h1400, "e0_slice1");
    observe('h1800, "e0_slice2");
    observe('h1C00, "e0_fixed");
    e0_mode = 1'b0; fe_mode = 1'b0;

    // 32K image: F4
    load_image(32768);
    do_reset();
    strobe('h1FFB, 1'b0, 0, "f4_hs7");
    observe('h1FFC, "f4_bank7");
    strobe('h1FF4, 1'b1, 0, "f4_frozen");
    observe('h1FFC, "f4_still7");
    rand_ops(150, 1'b0);

    // 16K image: F6, then reset, then a fresh load write at 0
    load_image(16384);
    strobe('h1FF9, 1'b0, 0, "f6_hs3");
    observe('h1234, "f6_bank3");
    do_reset();
    observe('h1234, "f6_after_reset");
    rand_ops(150, 1'b0);
    load_image(1);
    observe('h1234, "none_after_clear");
    rand_ops(50, 1'b0);

    tick(); tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
